// File: rtl/poly_tone_synth.sv
// -----------------------------------------------------------------------------
// poly_tone_synth
//
// Polyphonic square-wave tone generator for the music box speaker path.
// VOICES independent voices, each with a half-period divider, an amplitude
// and an optional linear decay envelope. Voice outputs are summed with
// saturation into a single registered PWM bit that drives the amp input.
//
// Ports:
//   CLK100MHZ     in   system clock, single clock domain
//   reset         in   synchronous, active-high reset
//   wr_en         in   one-cycle voice register write strobe
//   wr_voice      in   target voice index (out-of-range writes are ignored)
//   wr_div        in   half-period reload value, 0 = voice off
//   wr_amp        in   initial amplitude
//   wr_decay      in   1 = enable linear decay for this voice
//   voice_active  out  bit i = voice i has div!=0 and amp!=0
//   mix_level     out  registered saturated mix of all voices
//   pwm_out       out  registered PWM bit to the speaker
// -----------------------------------------------------------------------------
module poly_tone_synth #(
    parameter int VOICES    = 4,
    parameter int DIV_W     = 17,
    parameter int AMP_W     = 5,
    parameter int PWM_W     = 8,
    parameter int HEADROOM  = 1,
    parameter int DECAY_DIV = 1000000
) (
    input  logic                                              CLK100MHZ,
    input  logic                                              reset,
    input  logic                                              wr_en,
    input  logic [((VOICES > 1) ? $clog2(VOICES) : 1)-1:0]    wr_voice,
    input  logic [DIV_W-1:0]                                  wr_div,
    input  logic [AMP_W-1:0]                                  wr_amp,
    input  logic                                              wr_decay,
    output logic [VOICES-1:0]                                 voice_active,
    output logic [PWM_W-1:0]                                  mix_level,
    output logic                                              pwm_out
);

    localparam int VIDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int SUM_W  = AMP_W + $clog2(VOICES) + 1;
    // The adder is made at least PWM_W wide so the saturation compare and
    // the final slice never need a width special case.
    localparam int EXT_W  = (SUM_W > PWM_W) ? SUM_W : PWM_W;
    localparam int PCNT_W = PWM_W + HEADROOM;
    localparam int PRE_W  = $clog2(DECAY_DIV);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DECAY_DIV - 1);
    localparam logic [EXT_W-1:0] MIX_MAX  = EXT_W'((2 ** PWM_W) - 1);

    logic [DIV_W-1:0]  div_q      [VOICES];
    logic [DIV_W-1:0]  div_d      [VOICES];
    logic [DIV_W-1:0]  cnt_q      [VOICES];
    logic [DIV_W-1:0]  cnt_d      [VOICES];
    logic [AMP_W-1:0]  amp_q      [VOICES];
    logic [AMP_W-1:0]  amp_d      [VOICES];
    logic [VOICES-1:0] phase_q;
    logic [VOICES-1:0] phase_d;
    logic [VOICES-1:0] decay_en_q;
    logic [VOICES-1:0] decay_en_d;
    logic [PRE_W-1:0]  pre_q;
    logic [PRE_W-1:0]  pre_d;
    logic [PCNT_W-1:0] cnt_pwm_q;
    logic [PCNT_W-1:0] cnt_pwm_d;
    logic [PWM_W-1:0]  mix_level_q;
    logic [PWM_W-1:0]  mix_level_d;
    logic              pwm_out_q;
    logic              pwm_out_d;

    logic [VOICES-1:0] active_s;
    logic [VOICES-1:0] wr_hit_s;
    logic              tick_s;
    logic [EXT_W-1:0]  sum_s;

    // Voice activity from the registered divider and amplitude.
    always_comb begin
        for (int i = 0; i < VOICES; i++) begin
            active_s[i] = (div_q[i] != '0) && (amp_q[i] != '0);
        end
    end

    // Per-voice write decode; an index >= VOICES matches no voice.
    always_comb begin
        for (int i = 0; i < VOICES; i++) begin
            wr_hit_s[i] = wr_en && (wr_voice == VIDX_W'(i));
        end
    end

    // Decay tick fires on the cycle the prescaler wraps.
    always_comb begin
        tick_s = (pre_q == PRE_LAST);
        if (tick_s) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    // Voice next state: a write restarts the voice and suppresses a
    // coincident decay step; otherwise run the divider and the envelope.
    always_comb begin
        for (int i = 0; i < VOICES; i++) begin
            div_d[i]      = div_q[i];
            cnt_d[i]      = cnt_q[i];
            amp_d[i]      = amp_q[i];
            phase_d[i]    = phase_q[i];
            decay_en_d[i] = decay_en_q[i];
            if (wr_hit_s[i]) begin
                div_d[i]      = wr_div;
                cnt_d[i]      = wr_div;
                amp_d[i]      = wr_amp;
                phase_d[i]    = 1'b0;
                decay_en_d[i] = wr_decay;
            end else begin
                if (active_s[i]) begin
                    if (cnt_q[i] == '0) begin
                        cnt_d[i]   = div_q[i];
                        phase_d[i] = ~phase_q[i];
                    end else begin
                        cnt_d[i]   = cnt_q[i] - DIV_W'(1);
                    end
                end else begin
                    // Inactive voices keep their count but stay silent.
                    phase_d[i] = 1'b0;
                end
                if (tick_s && decay_en_q[i] && (amp_q[i] != '0)) begin
                    amp_d[i] = amp_q[i] - AMP_W'(1);
                end else begin
                    amp_d[i] = amp_q[i];
                end
            end
        end
    end

    // Saturating mix of every voice currently in its high half-period.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (phase_q[i] && active_s[i]) begin
                sum_s = sum_s + EXT_W'(amp_q[i]);
            end else begin
                sum_s = sum_s;
            end
        end
        if (sum_s > MIX_MAX) begin
            mix_level_d = MIX_MAX[PWM_W-1:0];
        end else begin
            mix_level_d = sum_s[PWM_W-1:0];
        end
    end

    // PWM counter and compare; headroom bits lengthen the period, which
    // scales the maximum duty down by a power of two.
    always_comb begin
        cnt_pwm_d = cnt_pwm_q + PCNT_W'(1);
        pwm_out_d = (PCNT_W'(mix_level_q) > cnt_pwm_q);
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            for (int i = 0; i < VOICES; i++) begin
                div_q[i] <= '0;
                cnt_q[i] <= '0;
                amp_q[i] <= '0;
            end
            phase_q     <= '0;
            decay_en_q  <= '0;
            pre_q       <= '0;
            cnt_pwm_q   <= '0;
            mix_level_q <= '0;
            pwm_out_q   <= 1'b0;
        end else begin
            for (int i = 0; i < VOICES; i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
                amp_q[i] <= amp_d[i];
            end
            phase_q     <= phase_d;
            decay_en_q  <= decay_en_d;
            pre_q       <= pre_d;
            cnt_pwm_q   <= cnt_pwm_d;
            mix_level_q <= mix_level_d;
            pwm_out_q   <= pwm_out_d;
        end
    end

    assign voice_active = active_s;
    assign mix_level    = mix_level_q;
    assign pwm_out      = pwm_out_q;

endmodule

// File: tb/tb_poly_tone_synth.sv
// -----------------------------------------------------------------------------
// tb_poly_tone_synth
//
// Two instances share clock and reset:
//   dut0: VOICES=3, PWM_W=8, HEADROOM=1, DECAY_DIV=4 (tone, PWM, decay,
//         collision, out-of-range write, retrigger)
//   dut1: VOICES=4, PWM_W=4, HEADROOM=1, DECAY_DIV=4 (saturation)
// Expected outputs come from a closed-form model: phase after edge j is
// ((j - write_edge) / (div + 1)) % 2 while active, amplitude drops by the
// number of prescaler wraps since the write, PWM counter is (j - reset_edge)
// modulo its period. Expectations are pushed to a scoreboard queue each
// cycle and popped when the DUT outputs are sampled.
// -----------------------------------------------------------------------------
module tb_poly_tone_synth;

    logic        clk = 1'b0;
    logic        reset;

    logic        wr_en0, wr_en1;
    logic [1:0]  wr_voice0, wr_voice1;
    logic [16:0] wr_div0, wr_div1;
    logic [4:0]  wr_amp0, wr_amp1;
    logic        wr_decay0, wr_decay1;
    logic [2:0]  act0;
    logic [3:0]  act1;
    logic [7:0]  mix0;
    logic [3:0]  mix1;
    logic        pwm0, pwm1;

    always #5 clk = ~clk;

    poly_tone_synth #(
        .VOICES(3), .DIV_W(17), .AMP_W(5), .PWM_W(8), .HEADROOM(1), .DECAY_DIV(4)
    ) dut0 (
        .CLK100MHZ(clk), .reset(reset), .wr_en(wr_en0), .wr_voice(wr_voice0),
        .wr_div(wr_div0), .wr_amp(wr_amp0), .wr_decay(wr_decay0),
        .voice_active(act0), .mix_level(mix0), .pwm_out(pwm0)
    );

    poly_tone_synth #(
        .VOICES(4), .DIV_W(17), .AMP_W(5), .PWM_W(4), .HEADROOM(1), .DECAY_DIV(4)
    ) dut1 (
        .CLK100MHZ(clk), .reset(reset), .wr_en(wr_en1), .wr_voice(wr_voice1),
        .wr_div(wr_div1), .wr_amp(wr_amp1), .wr_decay(wr_decay1),
        .voice_active(act1), .mix_level(mix1), .pwm_out(pwm1)
    );

    typedef struct {
        int mix;
        int pwm;
        int act;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp = 0;
    int n_err = 0;

    int m_div [2][4];
    int m_amp [2][4];
    int m_wr  [2][4];
    bit m_dec [2][4];
    int edge_n    = 0;
    int rst_edge  = 0;
    int prev_mix [2];

    bit pw_valid = 1'b0;
    int pw_s, pw_v, pw_div, pw_amp;
    bit pw_dec;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, edge_n, obs, exp);
        end
    endtask

    function automatic int nv(input int s);
        return (s == 0) ? 3 : 4;
    endfunction

    function automatic int amp_at(input int s, input int v, input int j);
        int t;
        int a;
        if (!m_dec[s][v]) return m_amp[s][v];
        t = (j - rst_edge) / 4 - (m_wr[s][v] - rst_edge) / 4;
        a = m_amp[s][v] - t;
        return (a < 0) ? 0 : a;
    endfunction

    function automatic bit act_at(input int s, input int v, input int j);
        return (m_div[s][v] != 0) && (amp_at(s, v, j) != 0);
    endfunction

    function automatic int phase_at(input int s, input int v, input int j);
        if (!act_at(s, v, j)) return 0;
        return ((j - m_wr[s][v]) / (m_div[s][v] + 1)) % 2;
    endfunction

    function automatic int mix_at(input int s, input int j);
        int sum = 0;
        int mx  = (s == 0) ? 255 : 15;
        for (int v = 0; v < nv(s); v++) begin
            if (phase_at(s, v, j) != 0) sum += amp_at(s, v, j);
        end
        return (sum > mx) ? mx : sum;
    endfunction

    function automatic int act_bits(input int s, input int j);
        int b = 0;
        for (int v = 0; v < nv(s); v++) begin
            if (act_at(s, v, j)) b |= (1 << v);
        end
        return b;
    endfunction

    function automatic int pcnt(input int s, input int j);
        return (j - rst_edge) % ((s == 0) ? 512 : 32);
    endfunction

    // One clock: push expectations for the coming edge, clock, pop and compare.
    task automatic step(input bit do_rst);
        int   k;
        exp_t e [2];
        exp_t got;
        k = edge_n + 1;
        for (int s = 0; s < 2; s++) begin
            if (do_rst) begin
                e[s] = '{0, 0, 0};
            end else begin
                e[s].mix = mix_at(s, edge_n);
                e[s].pwm = (prev_mix[s] > pcnt(s, edge_n)) ? 1 : 0;
                e[s].act = 0;
            end
        end
        if (do_rst) begin
            for (int s = 0; s < 2; s++) begin
                for (int v = 0; v < 4; v++) begin
                    m_div[s][v] = 0;
                    m_amp[s][v] = 0;
                    m_wr[s][v]  = 0;
                    m_dec[s][v] = 1'b0;
                end
            end
            rst_edge = k;
        end else if (pw_valid && (pw_v < nv(pw_s))) begin
            m_div[pw_s][pw_v] = pw_div;
            m_amp[pw_s][pw_v] = pw_amp;
            m_dec[pw_s][pw_v] = pw_dec;
            m_wr[pw_s][pw_v]  = k;
        end
        for (int s = 0; s < 2; s++) begin
            if (!do_rst) e[s].act = act_bits(s, k);
            sb_q.push_back(e[s]);
            prev_mix[s] = e[s].mix;
        end
        reset = do_rst;
        @(posedge clk);
        edge_n = k;
        #1;
        wr_en0   = 1'b0;
        wr_en1   = 1'b0;
        pw_valid = 1'b0;
        got = sb_q.pop_front();
        check_val("mix0", 32'(mix0), 32'(got.mix));
        check_val("pwm0", 32'(pwm0), 32'(got.pwm));
        check_val("act0", 32'(act0), 32'(got.act));
        got = sb_q.pop_front();
        check_val("mix1", 32'(mix1), 32'(got.mix));
        check_val("pwm1", 32'(pwm1), 32'(got.pwm));
        check_val("act1", 32'(act1), 32'(got.act));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic wr(input int s, input int v, input int dv, input int am, input bit dc);
        pw_valid = 1'b1;
        pw_s = s; pw_v = v; pw_div = dv; pw_amp = am; pw_dec = dc;
        if (s == 0) begin
            wr_en0 = 1'b1; wr_voice0 = 2'(v); wr_div0 = 17'(dv);
            wr_amp0 = 5'(am); wr_decay0 = dc;
        end else begin
            wr_en1 = 1'b1; wr_voice1 = 2'(v); wr_div1 = 17'(dv);
            wr_amp1 = 5'(am); wr_decay1 = dc;
        end
        step(1'b0);
    endtask

    initial begin
        int hi;
        reset = 1'b1;
        wr_en0 = 1'b0; wr_voice0 = 2'd0; wr_div0 = 17'd0; wr_amp0 = 5'd0; wr_decay0 = 1'b0;
        wr_en1 = 1'b0; wr_voice1 = 2'd0; wr_div1 = 17'd0; wr_amp1 = 5'd0; wr_decay1 = 1'b0;
        prev_mix[0] = 0;
        prev_mix[1] = 0;

        for (int i = 0; i < 3; i++) step(1'b1);

        // Reset response after arbitrary activity.
        wr(0, 0, 5, 9, 1'b1);
        wr(1, 2, 2, 20, 1'b0);
        wr(0, 2, 3, 17, 1'b0);
        run(20);
        for (int i = 0; i < 3; i++) step(1'b1);
        run(6);

        // Single voice: div=9, amp=5.
        wr(0, 0, 9, 5, 1'b0);
        run(45);

        // PWM duty: 5 of every 512 cycles while the voice is high.
        wr(0, 0, 1023, 5, 1'b0);
        run(1040);
        hi = 0;
        for (int i = 0; i < 512; i++) begin
            step(1'b0);
            if (pwm0 === 1'b1) hi++;
        end
        check_val("pwm_duty", 32'(hi), 32'd5);

        // Retrigger mid-period.
        wr(0, 0, 9, 5, 1'b0);
        run(14);
        wr(0, 0, 19, 5, 1'b0);
        run(45);

        // Saturation on the 4-bit instance.
        for (int v = 0; v < 4; v++) wr(1, v, 3, 31, 1'b0);
        run(20);
        wr(1, 0, 0, 31, 1'b0);
        run(12);

        // Decay: voice1 amp 3 -> 0.
        wr(0, 0, 0, 0, 1'b0);
        wr(0, 1, 1, 3, 1'b1);
        run(20);

        // Write colliding with a decay tick, then an out-of-range write.
        while (((edge_n + 1 - rst_edge) % 4) != 0) step(1'b0);
        wr(0, 2, 1, 7, 1'b1);
        run(3);
        wr(0, 3, 5, 31, 1'b0);
        run(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
